// File: rtl/stream_sink_monitor_pkg.sv
// Shared types and helpers for the stream sink monitor: stall modes, FSM states,
// LFSR tap constants and the saturating counter increment.
package stream_monitor_package;

  typedef enum logic [1:0] {
    STALL_NONE     = 2'd0,
    STALL_PERIODIC = 2'd1,
    STALL_RANDOM   = 2'd2,
    STALL_ALWAYS   = 2'd3
  } stall_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  // Maximal-length Galois taps (right-shifting form) for the supported widths.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       return 32'h0000_00B8;
      24:      return 32'h00E1_0000;
      32:      return 32'hA300_0000;
      default: return {16'h0000, LFSR_TAPS_16};
    endcase
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/stream_ready_gen.sv
// Backpressure gate generator: owns the shared LFSR and the period counter and
// produces the gate bit that will apply to ready during the next cycle.
module stream_ready_gen
  import stream_monitor_package::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        restart_i,
  input  logic        advance_i,
  input  stall_mode_e mode_i,
  input  logic [7:0]  period_i,
  input  logic [7:0]  thresh_i,
  output logic        gate_o
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;
  logic [7:0]        phase_q, phase_nxt, phase_inc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lfsr_nxt  = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    phase_inc = (restart_i ? 8'd0 : phase_q) + 8'd1;
    phase_nxt = (period_i <= 8'd1 || phase_inc >= period_i) ? 8'd0 : phase_inc;
    gate_o    = 1'b1;
    case (mode_i)
      STALL_NONE:     gate_o = 1'b1;
      STALL_PERIODIC: gate_o = (period_i <= 8'd1) || (phase_nxt != 8'd0);
      STALL_RANDOM:   gate_o = !(lfsr_nxt[7:0] < thresh_i);
      STALL_ALWAYS:   gate_o = 1'b0;
      default:        gate_o = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q  <= LFSR_W'(1);
      phase_q <= 8'd0;
    end else if (clear_i) begin
      lfsr_q  <= LFSR_W'(1);
      phase_q <= 8'd0;
    end else if (advance_i) begin
      lfsr_q  <= lfsr_nxt;
      phase_q <= phase_nxt;
    end
  end

endmodule

// File: rtl/stream_sink_monitor.sv
// Multi-channel hwpe stream sink with selectable backpressure and per-channel
// beat/stall/latency counters. Define STREAM_SINK_MONITOR_SIGNATURE_EN to add signature_o.
module stream_sink_monitor
  import stream_monitor_package::*;
#(
  parameter int N_CH   = 2,
  parameter int DW     = 128,
  parameter int CNT_W  = 32,
  parameter int LFSR_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [1:0]            stall_mode_i,
  input  logic [7:0]            stall_period_i,
  input  logic [7:0]            stall_thresh_i,
  input  logic [N_CH*CNT_W-1:0] expected_beats_i,
  input  logic [N_CH-1:0]       valid_i,
  input  logic [N_CH*DW-1:0]    data_i,
  input  logic [N_CH*DW/8-1:0]  strb_i,
  output logic [N_CH-1:0]       ready_o,
  output logic [N_CH*CNT_W-1:0] beats_o,
  output logic [N_CH*CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0]      total_cycles_o,
`ifdef STREAM_SINK_MONITOR_SIGNATURE_EN
  output logic [N_CH*32-1:0]    signature_o,
`endif
  output logic                  busy_o,
  output logic                  done_o
);

  state_e           state_q, state_nxt;
  stall_mode_e      mode_q, mode_nxt;
  logic             run, start_go, gate;
  logic [N_CH-1:0]  done_nxt;
  logic [CNT_W-1:0] total_q;

  assign run      = (state_q == RUN);
  assign start_go = start_i && !clear_i && !run;
  assign mode_nxt = start_go ? stall_mode_e'(stall_mode_i) : mode_q;

  // The run ends on the edge that registers the last outstanding handshake.
  always_comb begin
    state_nxt = state_q;
    if (clear_i)                state_nxt = IDLE;
    else if (start_go)          state_nxt = RUN;
    else if (run && &done_nxt)  state_nxt = DONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= STALL_NONE;
      total_q <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      mode_q  <= STALL_NONE;
      total_q <= '0;
    end else begin
      state_q <= state_nxt;
      mode_q  <= mode_nxt;
      if (start_go)  total_q <= '0;
      else if (run)  total_q <= CNT_W'(sat_inc(64'(total_q), CNT_W));
    end
  end

  stream_ready_gen #(
    .LFSR_W (LFSR_W)
  ) u_ready_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .restart_i (start_go),
    .advance_i (state_nxt == RUN),
    .mode_i    (mode_nxt),
    .period_i  (stall_period_i),
    .thresh_i  (stall_thresh_i),
    .gate_o    (gate)
  );

`ifdef STREAM_SINK_MONITOR_SIGNATURE_EN
  function automatic logic [31:0] fold32(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < DW/8; i++)
      if (s[i]) f[(i%4)*8 +: 8] = f[(i%4)*8 +: 8] ^ d[i*8 +: 8];
    return f;
  endfunction
`else
  logic unused_payload;
  assign unused_payload = ^{data_i, strb_i};
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] exp_q, exp_nxt, beats_q, beats_nxt, stall_q;
    logic             ready_q, hs, ch_done;

    assign hs        = run && valid_i[c] && ready_q;
    assign ch_done   = (beats_q == exp_q);
    assign exp_nxt   = start_go ? expected_beats_i[c*CNT_W +: CNT_W] : exp_q;
    assign beats_nxt = start_go ? '0
                     : hs       ? CNT_W'(sat_inc(64'(beats_q), CNT_W))
                     :            beats_q;
    assign done_nxt[c] = (beats_nxt == exp_nxt);

    // Ready looks one cycle ahead so it drops on the same edge as the final beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        exp_q   <= '0;
        beats_q <= '0;
        stall_q <= '0;
        ready_q <= 1'b0;
      end else if (clear_i) begin
        exp_q   <= '0;
        beats_q <= '0;
        stall_q <= '0;
        ready_q <= 1'b0;
      end else begin
        exp_q   <= exp_nxt;
        beats_q <= beats_nxt;
        ready_q <= (state_nxt == RUN) && !done_nxt[c] && gate;
        if (start_go)
          stall_q <= '0;
        else if (run && valid_i[c] && !ready_q && !ch_done)
          stall_q <= CNT_W'(sat_inc(64'(stall_q), CNT_W));
      end
    end

    assign ready_o[c]                        = ready_q;
    assign beats_o[c*CNT_W +: CNT_W]         = beats_q;
    assign stall_cycles_o[c*CNT_W +: CNT_W]  = stall_q;

`ifdef STREAM_SINK_MONITOR_SIGNATURE_EN
    logic [31:0] sig_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                 sig_q <= '0;
      else if (clear_i || start_go) sig_q <= '0;
      else if (hs)
        sig_q <= {sig_q[30:0], sig_q[31]} ^ fold32(data_i[c*DW +: DW], strb_i[c*DW/8 +: DW/8]);
    end
    assign signature_o[c*32 +: 32] = sig_q;
`endif
  end

  assign total_cycles_o = total_q;
  assign busy_o         = run;
  assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_stream_sink_monitor.sv
// Self-checking bench for stream_sink_monitor (N_CH=2, DW=32, CNT_W=8): directed
// scenarios plus randomized runs against a behavioural model. Honours STREAM_SINK_MONITOR_SIGNATURE_EN.
module tb_stream_sink_monitor;

  localparam int N_CH  = 2;
  localparam int DW    = 32;
  localparam int CNT_W = 8;
  localparam int MAXC  = 255;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  stall_mode_i = 2'd0;
  logic [7:0]  stall_period_i = 8'd0;
  logic [7:0]  stall_thresh_i = 8'd0;
  logic [15:0] expected_beats_i = '0;
  logic [1:0]  valid_i = '0;
  logic [63:0] data_i = '0;
  logic [7:0]  strb_i = 8'hFF;
  logic [1:0]  ready_o;
  logic [15:0] beats_o, stall_cycles_o;
  logic [7:0]  total_cycles_o;
  logic        busy_o, done_o;
`ifdef STREAM_SINK_MONITOR_SIGNATURE_EN
  logic [63:0] signature_o;
`endif

  stream_sink_monitor #(
    .N_CH(N_CH), .DW(DW), .CNT_W(CNT_W), .LFSR_W(16)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .start_i          (start_i),
    .stall_mode_i     (stall_mode_i),
    .stall_period_i   (stall_period_i),
    .stall_thresh_i   (stall_thresh_i),
    .expected_beats_i (expected_beats_i),
    .valid_i          (valid_i),
    .data_i           (data_i),
    .strb_i           (strb_i),
    .ready_o          (ready_o),
    .beats_o          (beats_o),
    .stall_cycles_o   (stall_cycles_o),
    .total_cycles_o   (total_cycles_o),
`ifdef STREAM_SINK_MONITOR_SIGNATURE_EN
    .signature_o      (signature_o),
`endif
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run/done flags, cycle index within the run, plain integer counters.
  bit          m_run, m_done;
  int          m_k, m_total;
  int          m_exp[N_CH], m_beats[N_CH], m_stall[N_CH];
  logic [1:0]  m_ready, m_mode;
  logic [15:0] m_lfsr;
  logic [31:0] m_sig[N_CH];

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic reset_model();
    m_run = 0; m_done = 0; m_k = 0; m_total = 0;
    m_ready = '0; m_mode = '0; m_lfsr = 16'h0001;
    for (int c = 0; c < N_CH; c++) begin
      m_exp[c] = 0; m_beats[c] = 0; m_stall[c] = 0; m_sig[c] = '0;
    end
  endtask

  // Gate for RUN cycle k of the run (k counts from 1).
  function automatic bit model_gate(input int k);
    int p;
    p = int'(stall_period_i);
    case (m_mode)
      2'd0:    return 1'b1;
      2'd1:    return (p <= 1) || (k % p != 0);
      2'd2:    return !(m_lfsr[7:0] < stall_thresh_i);
      default: return 1'b0;
    endcase
  endfunction

  task automatic enter_cycle();
    bit g;
    m_k++;
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    g = model_gate(m_k);
    for (int c = 0; c < N_CH; c++) m_ready[c] = g && (m_beats[c] != m_exp[c]);
  endtask

  task automatic run_cycle();
    bit all_done;
    logic [31:0] w;
    m_total = sat(m_total);
    all_done = 1;
    for (int c = 0; c < N_CH; c++) begin
      if (valid_i[c] && m_ready[c]) begin
        m_beats[c] = sat(m_beats[c]);
        w = '0;
        for (int b = 0; b < 4; b++)
          if (strb_i[c*4+b]) w[b*8 +: 8] = data_i[c*32 + b*8 +: 8];
        m_sig[c] = {m_sig[c][30:0], m_sig[c][31]} ^ w;
      end else if (valid_i[c] && m_beats[c] != m_exp[c]) begin
        m_stall[c] = sat(m_stall[c]);
      end
      if (m_beats[c] != m_exp[c]) all_done = 0;
    end
    if (all_done) begin
      m_run = 0; m_done = 1; m_ready = '0;
    end else begin
      enter_cycle();
    end
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i || clear_i) reset_model();
      else if (start_i && !m_run) begin
        m_run = 1; m_done = 0; m_k = 0; m_total = 0; m_mode = stall_mode_i;
        for (int c = 0; c < N_CH; c++) begin
          m_exp[c] = int'(expected_beats_i[c*8 +: 8]);
          m_beats[c] = 0; m_stall[c] = 0; m_sig[c] = '0;
        end
        enter_cycle();
      end else if (m_run) run_cycle();
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk_i);
      check("cmp_ready", 64'(ready_o), 64'(m_ready));
      check("cmp_beats", 64'(beats_o), 64'({m_beats[1][7:0], m_beats[0][7:0]}));
      check("cmp_stall", 64'(stall_cycles_o), 64'({m_stall[1][7:0], m_stall[0][7:0]}));
      check("cmp_total", 64'(total_cycles_o), 64'(m_total[7:0]));
      check("cmp_busy",  64'(busy_o), 64'(m_run));
      check("cmp_done",  64'(done_o), 64'(m_done));
`ifdef STREAM_SINK_MONITOR_SIGNATURE_EN
      check("cmp_sig", signature_o, {m_sig[1], m_sig[0]});
`endif
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check("wait_done", 64'(done_o), 64'd1);
  endtask

  initial begin
    repeat (3) drive_edge();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);

    // Always ready, expected {4,3}.
    drive_edge();
    stall_mode_i = 2'd0; expected_beats_i = 16'h0304; valid_i = 2'b11; start_i = 1'b1;
    drive_edge();
    start_i = 1'b0;
    @(negedge clk_i);
    check("t1_ready_first", 64'(ready_o), 64'd3);
    repeat (3) @(negedge clk_i);
    check("t1_ch1_ready_drop", 64'(ready_o), 64'd1);
    wait_done(20);
    check("t1_total", 64'(total_cycles_o), 64'd4);
    check("t1_beats", 64'(beats_o), 64'h0304);
    check("t1_stall", 64'(stall_cycles_o), 64'h0000);

    // Periodic stall, period 4, expected {8,8}.
    drive_edge();
    stall_mode_i = 2'd1; stall_period_i = 8'd4; expected_beats_i = 16'h0808; start_i = 1'b1;
    drive_edge();
    start_i = 1'b0;
    @(negedge clk_i);
    wait_done(40);
    check("t2_total", 64'(total_cycles_o), 64'd10);
    check("t2_stall", 64'(stall_cycles_o), 64'h0202);
    check("t2_beats", 64'(beats_o), 64'h0808);

    // Never ready for 5 cycles, then clear.
    drive_edge();
    stall_mode_i = 2'd3; expected_beats_i = 16'h0505; start_i = 1'b1;
    drive_edge();
    start_i = 1'b0;
    repeat (5) drive_edge();
    @(negedge clk_i);
    check("t3_stall", 64'(stall_cycles_o), 64'h0505);
    check("t3_total", 64'(total_cycles_o), 64'd5);
    drive_edge();
    clear_i = 1'b1;
    drive_edge();
    clear_i = 1'b0;
    @(negedge clk_i);
    check("t3_clr_outputs", 64'({ready_o, beats_o, stall_cycles_o, total_cycles_o, busy_o, done_o}), 64'd0);

    // Counter saturation.
    drive_edge();
    stall_mode_i = 2'd3; expected_beats_i = 16'hC8C8; start_i = 1'b1;
    drive_edge();
    start_i = 1'b0;
    repeat (300) drive_edge();
    @(negedge clk_i);
    check("sat_stall", 64'(stall_cycles_o), 64'hFFFF);
    check("sat_total", 64'(total_cycles_o), 64'hFF);
    drive_edge();
    clear_i = 1'b1;
    drive_edge();

    // Start together with clear: clear wins.
    stall_mode_i = 2'd0; expected_beats_i = 16'h0101; start_i = 1'b1; clear_i = 1'b1;
    drive_edge();
    start_i = 1'b0; clear_i = 1'b0;
    @(negedge clk_i);
    check("start_clear_busy", 64'(busy_o), 64'd0);

    // expected {0,2}: ch0 never ready.
    drive_edge();
    expected_beats_i = 16'h0200; start_i = 1'b1;
    drive_edge();
    start_i = 1'b0;
    @(negedge clk_i);
    check("t4_ready", 64'(ready_o), 64'd2);
    wait_done(20);
    check("t4_beats", 64'(beats_o), 64'h0200);
    check("t4_total", 64'(total_cycles_o), 64'd2);

    // Reset mid-run after 3 beats, then a fresh run.
    drive_edge();
    expected_beats_i = 16'h0A0A; start_i = 1'b1;
    drive_edge();
    start_i = 1'b0;
    repeat (3) drive_edge();
    @(negedge clk_i);
    check("t5_beats_mid", 64'(beats_o), 64'h0303);
    drive_edge();
    rst_i = 1'b1;
    #1;
    check("t5_rst_outputs", 64'({ready_o, beats_o, stall_cycles_o, total_cycles_o, busy_o, done_o}), 64'd0);
    drive_edge();
    rst_i = 1'b0;
    expected_beats_i = 16'h0304; start_i = 1'b1;
    drive_edge();
    start_i = 1'b0;
    @(negedge clk_i);
    wait_done(20);
    check("t5_total", 64'(total_cycles_o), 64'd4);
    check("t5_beats", 64'(beats_o), 64'h0304);

`ifdef STREAM_SINK_MONITOR_SIGNATURE_EN
    // Signature: beats 0x1 then 0x2 on ch0, full strobes then a zero strobe on beat 2.
    for (int pass = 0; pass < 2; pass++) begin
      drive_edge();
      valid_i = 2'b01; expected_beats_i = 16'h0002; data_i = 64'h1; strb_i = 8'hFF; start_i = 1'b1;
      drive_edge();
      start_i = 1'b0;
      drive_edge();
      data_i = 64'h2;
      if (pass == 1) strb_i = 8'hF0;
      drive_edge();
      @(negedge clk_i);
      check("sig_value", 64'(signature_o[31:0]), (pass == 0) ? 64'h0 : 64'h2);
    end
    strb_i = 8'hFF;
`endif

    // Randomized runs.
    for (int run = 0; run < 40; run++) begin
      drive_edge();
      stall_mode_i     = 2'($urandom_range(0, 3));
      stall_period_i   = 8'($urandom_range(0, 6));
      stall_thresh_i   = 8'($urandom_range(0, 200));
      expected_beats_i = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
      start_i = 1'b1;
      drive_edge();
      start_i = 1'b0;
      for (int cyc = 0; cyc < ((stall_mode_i == 2'd3) ? 30 : 400); cyc++) begin
        valid_i = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        data_i  = {$urandom, $urandom};
        strb_i  = 8'($urandom);
        start_i = ($urandom_range(0, 19) == 0);
        clear_i = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 299) == 0) begin
          rst_i = 1'b1;
          #2;
          rst_i = 1'b0;
        end
        drive_edge();
        start_i = 1'b0;
        clear_i = 1'b0;
        if (done_o || !busy_o) break;
      end
      if (busy_o && stall_mode_i != 2'd3)
        check("rand_run_timeout", 64'(busy_o), 64'd0);
      if (busy_o) begin
        clear_i = 1'b1;
        drive_edge();
        clear_i = 1'b0;
      end
    end

    valid_i = '0;
    repeat (2) drive_edge();
    @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
